// File: rtl/vmask_packer.sv
// ============================================================================
// Module   : vmask_packer
// Brief    : Evaluates vector compare predicates on per-element flags and packs
//            the result bits into mask words behind a one-entry output register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vmask_packer #(
  parameter int REQ_DATA_WIDTH = 64,
  parameter int SEW_WIDTH      = 2,
  parameter int MASK_WIDTH     = 8,
  parameter int CNT_WIDTH      = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEW_WIDTH-1:0]      in_sew,
  input  logic [2:0]                in_op,
  input  logic [MASK_WIDTH-1:0]     in_equal,
  input  logic [MASK_WIDTH-1:0]     in_lt,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REQ_DATA_WIDTH-1:0] out_mask,
  output logic [CNT_WIDTH-1:0]      out_count,
  output logic                      out_last
);

  localparam logic [2:0] C_OP_NE = 3'd1;
  localparam logic [2:0] C_OP_LT = 3'd2;
  localparam logic [2:0] C_OP_LE = 3'd3;
  localparam logic [2:0] C_OP_GT = 3'd4;
  localparam logic [2:0] C_OP_GE = 3'd5;

  logic [REQ_DATA_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0]      fill_q, fill_d;
  logic [REQ_DATA_WIDTH-1:0] out_mask_q, out_mask_d;
  logic [CNT_WIDTH-1:0]      out_count_q, out_count_d;
  logic                      out_last_q, out_last_d;
  logic                      out_valid_q, out_valid_d;

  logic [CNT_WIDTH-1:0]      w_n;
  logic [MASK_WIDTH-1:0]     w_sel;
  logic [MASK_WIDTH-1:0]     w_pred;
  logic [MASK_WIDTH-1:0]     w_bits;
  logic [REQ_DATA_WIDTH-1:0] w_merged;
  logic [CNT_WIDTH-1:0]      w_sum;
  logic                      w_accept;
  logic                      w_flush;

  assign w_n   = CNT_WIDTH'(MASK_WIDTH) >> in_sew;
  assign w_sel = ~({MASK_WIDTH{1'b1}} << w_n);

  always_comb begin
    w_pred = in_equal;
    case (in_op)
      C_OP_NE: w_pred = ~in_equal;
      C_OP_LT: w_pred = in_lt;
      C_OP_LE: w_pred = in_lt | in_equal;
      C_OP_GT: w_pred = ~in_lt & ~in_equal;
      C_OP_GE: w_pred = ~in_lt;
      default: w_pred = in_equal;
    endcase
  end

  assign w_bits   = w_pred & w_sel;
  assign w_merged = acc_q | ({{(REQ_DATA_WIDTH-MASK_WIDTH){1'b0}}, w_bits} << fill_q);
  assign w_sum    = fill_q + w_n;

  // Any accepted beat may flush, so beats are only taken when the output slot frees up.
  assign in_ready = ~out_valid_q | out_ready;
  assign w_accept = in_valid & in_ready;
  assign w_flush  = w_accept & ((w_sum == CNT_WIDTH'(REQ_DATA_WIDTH)) | in_last);

  always_comb begin
    acc_d       = acc_q;
    fill_d      = fill_q;
    out_mask_d  = out_mask_q;
    out_count_d = out_count_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q & ~out_ready;
    if (w_flush) begin
      acc_d       = '0;
      fill_d      = '0;
      out_mask_d  = w_merged;
      out_count_d = w_sum;
      out_last_d  = in_last;
      out_valid_d = 1'b1;
    end else if (w_accept) begin
      acc_d  = w_merged;
      fill_d = w_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      fill_q      <= '0;
      out_mask_q  <= '0;
      out_count_q <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      fill_q      <= fill_d;
      out_mask_q  <= out_mask_d;
      out_count_q <= out_count_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_mask  = out_mask_q;
  assign out_count = out_count_q;
  assign out_last  = out_last_q;

endmodule

`default_nettype wire
